// File: rtl/color_state_pkg.sv
// Shared encodings and helpers for the colour-to-cell-state packer family.
package color_state_pkg;

    localparam logic [1:0] UNK_DEAD  = 2'd0;
    localparam logic [1:0] UNK_ALIVE = 2'd1;
    localparam logic [1:0] UNK_ERR   = 2'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input longint unsigned value);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/color_state_packer_if.sv
// Pixel-in / packed-word-out streams of the colour state packer.
// Both streams: a beat transfers on a rising clock edge where valid & ready;
// the source holds data and markers stable while valid & ~ready.
interface color_state_packer_if #(
    parameter int DWIDTH = 32,
    parameter int PACK   = 32
);
    logic [DWIDTH-1:0] s_pix_data;
    logic              s_pix_sof;
    logic              s_pix_valid;
    logic              s_pix_ready;
    logic [PACK-1:0]   m_word_data;
    logic              m_word_eol;
    logic              m_word_eof;
    logic              m_word_valid;
    logic              m_word_ready;

    modport slave (
        input  s_pix_data, s_pix_sof, s_pix_valid, m_word_ready,
        output s_pix_ready, m_word_data, m_word_eol, m_word_eof, m_word_valid
    );

    modport master (
        output s_pix_data, s_pix_sof, s_pix_valid, m_word_ready,
        input  s_pix_ready, m_word_data, m_word_eol, m_word_eof, m_word_valid
    );
endinterface

// File: rtl/color_classify.sv
// Masked colour compare of one pixel against the alive/dead reference colours.
module color_classify
    import color_state_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] data,
    input  logic [DWIDTH-1:0] alive,
    input  logic [DWIDTH-1:0] dead,
    input  logic [DWIDTH-1:0] mask,
    input  logic [1:0]        mode,
    output logic              state,
    output logic              unknown_err
);
    logic match_a;
    logic match_d;
    logic unknown;

    assign match_a = ((data ^ alive) & mask) == '0;
    assign match_d = ((data ^ dead) & mask) == '0;
    assign unknown = ~match_a & ~match_d;

    // Alive wins when both references match under the mask.
    assign state       = match_a | (unknown & (mode == UNK_ALIVE));
    assign unknown_err = unknown & (mode >= UNK_ERR);
endmodule

// File: rtl/color_state_packer.sv
// Streams pixels into Game-of-Life cell states, packed PACK per word with
// row/frame markers, plus per-frame alive count and sticky error flags.
module color_state_packer
    import color_state_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int PACK   = 32,
    localparam int CNTW  = clog2(WIDTH * HEIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] cfg_alive_color,
    input  logic [DWIDTH-1:0] cfg_dead_color,
    input  logic [DWIDTH-1:0] cfg_color_mask,
    input  logic [1:0]        cfg_unknown_mode,
    color_state_packer_if.slave bus,
    output logic [CNTW-1:0]   frame_alive_cnt,
    output logic              frame_done,
    output logic              err_unknown,
    output logic              err_sync,
    input  logic              clear_err,
    output state_t            state_dbg
);
    localparam int XW = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? clog2(HEIGHT) : 1;
    localparam int PW = (PACK > 1) ? clog2(PACK) : 1;

    state_t          state;
    state_t          state_next;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [PW-1:0]   pack_cnt;
    logic [PACK-1:0] shift;
    logic [CNTW-1:0] acc;
    logic [PACK-1:0] word_data;
    logic            word_eol;
    logic            word_eof;
    logic            word_valid;

    logic            pix_state;
    logic            pix_unknown;
    logic            pix_ready;
    logic            accept;
    logic            restart;
    logic            drop;
    logic            take;
    logic [XW-1:0]   cur_x;
    logic [YW-1:0]   cur_y;
    logic [PW-1:0]   cur_pack;
    logic [PACK-1:0] cur_shift;
    logic [CNTW-1:0] cur_acc;
    logic            last_col;
    logic            last_row;
    logic            last_pix;
    logic            word_done;
    logic [PACK-1:0] packed_word;
    logic [CNTW-1:0] acc_next;

    color_classify #(.DWIDTH(DWIDTH)) u_classify (
        .data        (bus.s_pix_data),
        .alive       (cfg_alive_color),
        .dead        (cfg_dead_color),
        .mask        (cfg_color_mask),
        .mode        (cfg_unknown_mode),
        .state       (pix_state),
        .unknown_err (pix_unknown)
    );

    // IDLE always accepts; PACK >= 2 guarantees an sof pixel never completes a word.
    assign pix_ready = (state == IDLE) | ~word_valid | bus.m_word_ready;
    assign accept    = bus.s_pix_valid & pix_ready;
    assign drop      = accept & (state == IDLE) & ~bus.s_pix_sof;
    assign take      = accept & ~drop;
    assign restart   = accept & bus.s_pix_sof &
                       ((state == IDLE) | (x != '0) | (y != '0));

    // A restarting pixel sees a clean frame: position, pack and count at zero.
    assign cur_x     = restart ? '0 : x;
    assign cur_y     = restart ? '0 : y;
    assign cur_pack  = restart ? '0 : pack_cnt;
    assign cur_shift = restart ? '0 : shift;
    assign cur_acc   = restart ? '0 : acc;

    assign last_col    = cur_x == XW'(WIDTH - 1);
    assign last_row    = cur_y == YW'(HEIGHT - 1);
    assign last_pix    = last_col & last_row;
    assign word_done   = take & (cur_pack == PW'(PACK - 1));
    assign packed_word = cur_shift | (PACK'(pix_state) << cur_pack);
    assign acc_next    = cur_acc + CNTW'(pix_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (take) state_next = last_pix ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x               <= '0;
            y               <= '0;
            pack_cnt        <= '0;
            shift           <= '0;
            acc             <= '0;
            word_data       <= '0;
            word_eol        <= 1'b0;
            word_eof        <= 1'b0;
            word_valid      <= 1'b0;
            frame_alive_cnt <= '0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (word_valid && bus.m_word_ready) word_valid <= 1'b0;
            if (take) begin
                x <= last_col ? '0 : cur_x + XW'(1);
                if (last_col) y <= last_row ? '0 : cur_y + YW'(1);
                else          y <= cur_y;
                if (word_done) begin
                    shift      <= '0;
                    pack_cnt   <= '0;
                    word_data  <= packed_word;
                    word_eol   <= last_col;
                    word_eof   <= last_pix;
                    word_valid <= 1'b1;
                end else begin
                    shift    <= packed_word;
                    pack_cnt <= cur_pack + PW'(1);
                end
                if (last_pix) begin
                    frame_alive_cnt <= acc_next;
                    acc             <= '0;
                    frame_done      <= 1'b1;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unknown <= 1'b0;
            err_sync    <= 1'b0;
        end else if (clear_err) begin
            err_unknown <= 1'b0;
            err_sync    <= 1'b0;
        end else begin
            if (drop || (restart && state == ACTIVE)) err_sync <= 1'b1;
            if (take && pix_unknown)                  err_unknown <= 1'b1;
        end
    end

    assign bus.s_pix_ready  = pix_ready;
    assign bus.m_word_data  = word_data;
    assign bus.m_word_eol   = word_eol;
    assign bus.m_word_eof   = word_eof;
    assign bus.m_word_valid = word_valid;
    assign state_dbg        = state;
endmodule
